// File: rtl/vdp_bus_bridge.sv
// vdp_bus_bridge: TI-99/4A CPU port decode and byte-strobe sequencer
// sitting directly in front of the tms9918 VDP host port.
module vdp_bus_bridge #(
    parameter int RD_CYCLES       = 4,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:1] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_data_in,
    output logic [15:0] cpu_data_out,
    output logic        cpu_ready,
    output logic        cpu_ack,
    output logic        vdp_mode,
    output logic [7:0]  vdp_addr,
    output logic [7:0]  vdp_data_in,
    output logic        vdp_wr,
    output logic        vdp_rd,
    input  logic [15:0] vdp_data_out
);

    typedef enum logic [2:0] {
        IDLE, SETUP, WPULSE, RPULSE, DONE, ACK_ONLY, RECOVER
    } state_t;

    localparam logic [3:0] RD_LOAD  = 4'(RD_CYCLES);
    localparam logic [3:0] REC_LOAD = 4'(RECOVERY_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic       rd_op;
    logic       sel_rd;
    logic       sel_wr;
    logic       unused_bits;

    assign sel_rd      = (cpu_addr[15:10] == 6'b100010);
    assign sel_wr      = (cpu_addr[15:10] == 6'b100011);
    assign vdp_addr    = 8'h00;
    assign unused_bits = ^{cpu_addr[9:2], cpu_data_in[7:0],
                           vdp_data_out[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            rd_op        <= 1'b0;
            cpu_ready    <= 1'b1;
            cpu_ack      <= 1'b0;
            cpu_data_out <= 16'h0000;
            vdp_mode     <= 1'b0;
            vdp_data_in  <= 8'h00;
            vdp_wr       <= 1'b0;
            vdp_rd       <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_rd || cpu_wr) begin
                        cpu_ready <= 1'b0;
                        // a simultaneous rd+wr is treated as a write
                        unique case (1'b1)
                            cpu_wr && sel_wr: begin
                                state       <= SETUP;
                                rd_op       <= 1'b0;
                                vdp_mode    <= cpu_addr[1];
                                vdp_data_in <= cpu_data_in[15:8];
                            end
                            !cpu_wr && sel_rd: begin
                                state    <= SETUP;
                                rd_op    <= 1'b1;
                                vdp_mode <= cpu_addr[1];
                            end
                            !cpu_wr && sel_wr: begin
                                state        <= ACK_ONLY;
                                cpu_ack      <= 1'b1;
                                cpu_data_out <= 16'h0000;
                            end
                            default: begin
                                state   <= ACK_ONLY;
                                cpu_ack <= 1'b1;
                            end
                        endcase
                    end
                end
                SETUP: begin
                    if (rd_op) begin
                        state  <= RPULSE;
                        vdp_rd <= 1'b1;
                        cnt    <= RD_LOAD;
                    end else begin
                        state  <= WPULSE;
                        vdp_wr <= 1'b1;
                    end
                end
                WPULSE: begin
                    state   <= DONE;
                    vdp_wr  <= 1'b0;
                    cpu_ack <= 1'b1;
                end
                RPULSE: begin
                    // one contiguous strobe: status reads clear VDP flags
                    if (cnt == 4'd1) begin
                        state        <= DONE;
                        vdp_rd       <= 1'b0;
                        cpu_ack      <= 1'b1;
                        cnt          <= 4'd0;
                        cpu_data_out <= {vdp_data_out[15:8], 8'h00};
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE, ACK_ONLY: begin
                    if (REC_LOAD == 4'd0) begin
                        state     <= IDLE;
                        cpu_ready <= 1'b1;
                    end else begin
                        state <= RECOVER;
                        cnt   <= REC_LOAD;
                    end
                end
                RECOVER: begin
                    if (cnt <= 4'd1) begin
                        state     <= IDLE;
                        cpu_ready <= 1'b1;
                        cnt       <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_bus_bridge.sv
// tb_vdp_bus_bridge: timeline model plus a small VDP host-port stub
// driving directed TI-99/4A port accesses through the bridge.
module tb_vdp_bus_bridge;

    localparam int RD  = 4;
    localparam int REC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:1] cpu_addr;
    logic        cpu_rd, cpu_wr;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_out;
    logic        cpu_ready, cpu_ack;
    logic        vdp_mode;
    logic [7:0]  vdp_addr, vdp_data_in;
    logic        vdp_wr, vdp_rd;
    logic [15:0] vdp_data_out;

    logic        z_wr, z_rd;
    logic [15:0] z_data_out;
    logic        z_ready, z_ack, z_mode, z_vwr, z_vrd;
    logic [7:0]  z_addr, z_din;

    always #20 clk = ~clk;

    vdp_bus_bridge #(.RD_CYCLES(RD), .RECOVERY_CYCLES(REC)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_data_in(cpu_data_in),
        .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
        .cpu_ack(cpu_ack), .vdp_mode(vdp_mode), .vdp_addr(vdp_addr),
        .vdp_data_in(vdp_data_in), .vdp_wr(vdp_wr), .vdp_rd(vdp_rd),
        .vdp_data_out(vdp_data_out)
    );

    vdp_bus_bridge #(.RD_CYCLES(RD), .RECOVERY_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr),
        .cpu_rd(z_rd), .cpu_wr(z_wr), .cpu_data_in(cpu_data_in),
        .cpu_data_out(z_data_out), .cpu_ready(z_ready),
        .cpu_ack(z_ack), .vdp_mode(z_mode), .vdp_addr(z_addr),
        .vdp_data_in(z_din), .vdp_wr(z_vwr), .vdp_rd(z_vrd),
        .vdp_data_out(vdp_data_out)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // VDP host-port stub: byte latch, address counter, frame flag
    logic [7:0]  vram [0:16383];
    logic [7:0]  vreg [0:7];
    logic [13:0] vaddr     = 14'd0;
    logic [7:0]  latch_b   = 8'h00;
    logic        latch_f   = 1'b0;
    logic        vflag     = 1'b0;
    logic        rd_q      = 1'b0;
    logic        rd_mode_q = 1'b0;
    logic        frame_set;

    always_comb begin
        vdp_data_out = 16'hFFFF;
        if (vdp_rd)
            vdp_data_out = vdp_mode ? {vflag, 7'h00, 8'hA5}
                                    : {vram[vaddr], 8'hA5};
    end

    always @(posedge clk) begin
        rd_q <= vdp_rd;
        if (vdp_rd) rd_mode_q <= vdp_mode;
        if (vdp_wr) begin
            if (vdp_mode && !latch_f) begin
                latch_b <= vdp_data_in;
                latch_f <= 1'b1;
            end else if (vdp_mode) begin
                latch_f <= 1'b0;
                if (vdp_data_in[7]) vreg[vdp_data_in[2:0]] <= latch_b;
                else vaddr <= {vdp_data_in[5:0], latch_b};
            end else begin
                vram[vaddr] <= vdp_data_in;
                vaddr       <= vaddr + 14'd1;
                latch_f     <= 1'b0;
            end
        end
        if (rd_q && !vdp_rd) begin
            latch_f <= 1'b0;
            if (rd_mode_q) vflag <= 1'b0;
            else vaddr <= vaddr + 14'd1;
        end
        if (frame_set) vflag <= 1'b1;
    end

    // timeline model: each accepted access schedules its strobe,
    // ack and busy window in absolute cycle numbers
    int          m_cyc    = 0;
    int          busy_end = 0;
    int          ack_at   = -1;
    int          wr_at    = -1;
    int          rd_from  = -1;
    int          rd_to    = -2;
    int          cap_at   = -1;
    logic        m_mode   = 1'b0;
    logic [7:0]  m_din    = 8'h00;
    logic [15:0] m_dout   = 16'h0000;
    logic [15:0] m_a;
    logic        m_ar, m_aw;

    always @(posedge clk) begin
        m_cyc++;
        if (reset) begin
            busy_end = 0; ack_at = -1; wr_at = -1;
            rd_from = -1; rd_to = -2; cap_at = -1;
            m_mode = 1'b0; m_din = 8'h00; m_dout = 16'h0000;
        end else begin
            if (m_cyc == cap_at) m_dout = {vdp_data_out[15:8], 8'h00};
            if (m_cyc - 1 >= busy_end && (cpu_rd || cpu_wr)) begin
                m_a  = {cpu_addr, 1'b0};
                m_ar = (m_a >= 16'h8800) && (m_a <= 16'h8BFF);
                m_aw = (m_a >= 16'h8C00) && (m_a <= 16'h8FFF);
                if (cpu_wr && m_aw) begin
                    m_mode   = (m_a & 16'h0002) != 16'h0;
                    m_din    = cpu_data_in[15:8];
                    wr_at    = m_cyc + 1;
                    ack_at   = m_cyc + 2;
                    busy_end = m_cyc + 3 + REC;
                end else if (!cpu_wr && m_ar) begin
                    m_mode   = (m_a & 16'h0002) != 16'h0;
                    rd_from  = m_cyc + 1;
                    rd_to    = m_cyc + RD;
                    cap_at   = rd_to + 1;
                    ack_at   = cap_at;
                    busy_end = cap_at + 1 + REC;
                end else begin
                    ack_at   = m_cyc;
                    busy_end = m_cyc + 1 + REC;
                    if (!cpu_wr && m_aw) m_dout = 16'h0000;
                end
            end
        end
    end

    int wr_times[$];
    int z_times[$];
    int rd_clocks = 0;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_ready", cpu_ready, 1'b1);
            chk("rst_ack", cpu_ack, 1'b0);
            chk("rst_dout", cpu_data_out, 16'h0);
            chk("rst_mode", vdp_mode, 1'b0);
            chk("rst_din", vdp_data_in, 8'h0);
            chk("rst_wr", vdp_wr, 1'b0);
            chk("rst_rd", vdp_rd, 1'b0);
        end else begin
            chk("ready", cpu_ready, m_cyc >= busy_end);
            chk("ack", cpu_ack, m_cyc == ack_at);
            chk("vdp_wr", vdp_wr, m_cyc == wr_at);
            chk("vdp_rd", vdp_rd, m_cyc >= rd_from && m_cyc <= rd_to);
            chk("vdp_mode", vdp_mode, m_mode);
            chk("vdp_data_in", vdp_data_in, m_din);
            chk("cpu_data_out", cpu_data_out, m_dout);
        end
        chk("vdp_addr", vdp_addr, 8'h00);
        if (vdp_wr) wr_times.push_back(m_cyc);
        if (z_vwr) z_times.push_back(m_cyc);
        if (vdp_rd) rd_clocks++;
    end

    task automatic access(input logic [15:0] a, input logic [15:0] d,
                          input logic w, input logic r,
                          output int lat, output int low);
        int n = 0;
        lat = 0;
        @(negedge clk);
        while (!cpu_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", cpu_ready, 1'b1);
        cpu_addr    = a[15:1];
        cpu_data_in = d;
        cpu_wr      = w;
        cpu_rd      = r;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ack && lat < 50);
        chk("ack_seen", cpu_ack, 1'b1);
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        low = lat;
        n = 0;
        @(negedge clk);
        while (!cpu_ready && n < 50) begin
            low++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cpu_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", cpu_ready, 1'b1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, low, w0, r0, gap1, gap2;
        logic [15:0] a;
        reset = 1'b1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; z_wr = 1'b0; z_rd = 1'b0;
        cpu_data_in = 16'h0; frame_set = 1'b0;
        a = 16'h0; cpu_addr = a[15:1];
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // register setup
        wr_times.delete();
        access(16'h8C02, 16'h0000, 1'b1, 1'b0, lat, low);
        chk("reg_lat", lat, 3);
        chk("reg_low", low, 3 + REC);
        chk("reg_din0", vdp_data_in, 8'h00);
        access(16'h8C02, 16'h8000, 1'b1, 1'b0, lat, low);
        chk("reg_lat2", lat, 3);
        chk("reg_din1", vdp_data_in, 8'h80);
        chk("reg_mode", vdp_mode, 1'b1);
        chk("reg_pulses", wr_times.size(), 2);
        chk("reg_vreg0", vreg[0], 8'h00);

        // memory write and readback
        access(16'h8C02, 16'h3400, 1'b1, 1'b0, lat, low);
        access(16'h8C02, 16'h5200, 1'b1, 1'b0, lat, low);
        access(16'h8C00, 16'h5A00, 1'b1, 1'b0, lat, low);
        access(16'h8C00, 16'hEE00, 1'b1, 1'b0, lat, low);
        access(16'h8C02, 16'h3400, 1'b1, 1'b0, lat, low);
        access(16'h8C02, 16'h1200, 1'b1, 1'b0, lat, low);
        r0 = rd_clocks;
        access(16'h8800, 16'h0000, 1'b0, 1'b1, lat, low);
        chk("mem_rd0", cpu_data_out, 16'h5A00);
        chk("mem_rd_lat", lat, RD + 2);
        chk("mem_rd_low", low, RD + 2 + REC);
        chk("mem_rd_clocks", rd_clocks - r0, RD);
        chk("mem_rd_mode", vdp_mode, 1'b0);
        access(16'h8800, 16'h0000, 1'b0, 1'b1, lat, low);
        chk("mem_rd1", cpu_data_out, 16'hEE00);

        // decode and mirrors
        r0 = rd_clocks;
        access(16'h9000, 16'h0000, 1'b0, 1'b1, lat, low);
        chk("unmap_rd_keep", cpu_data_out, 16'hEE00);
        chk("unmap_rd_lat", lat, 1);
        chk("unmap_rd_low", low, 1 + REC);
        w0 = wr_times.size();
        access(16'h8800, 16'h1234, 1'b1, 1'b0, lat, low);
        chk("wr_rdarea_lat", lat, 1);
        chk("wr_rdarea_pulses", wr_times.size() - w0, 0);
        chk("wr_rdarea_keep", cpu_data_out, 16'hEE00);
        access(16'h8C00, 16'h0000, 1'b0, 1'b1, lat, low);
        chk("rd_wrarea_zero", cpu_data_out, 16'h0000);
        chk("unmap_rd_clocks", rd_clocks - r0, 0);
        access(16'h8C06, 16'h1100, 1'b1, 1'b0, lat, low);
        chk("mirror_mode", vdp_mode, 1'b1);
        chk("mirror_din", vdp_data_in, 8'h11);
        access(16'h8C02, 16'h8100, 1'b1, 1'b0, lat, low);
        chk("mirror_vreg1", vreg[1], 8'h11);

        // status read clears the frame flag
        @(negedge clk); frame_set = 1'b1;
        @(negedge clk); frame_set = 1'b0;
        r0 = rd_clocks;
        access(16'h8802, 16'h0000, 1'b0, 1'b1, lat, low);
        chk("status_set", cpu_data_out, 16'h8000);
        chk("status_rd_clocks", rd_clocks - r0, RD);
        access(16'h8802, 16'h0000, 1'b0, 1'b1, lat, low);
        chk("status_clear", cpu_data_out, 16'h0000);

        // rd and wr together: write wins
        r0 = rd_clocks;
        w0 = wr_times.size();
        access(16'h8C00, 16'h3C00, 1'b1, 1'b1, lat, low);
        chk("both_lat", lat, 3);
        chk("both_rd_clocks", rd_clocks - r0, 0);
        chk("both_pulses", wr_times.size() - w0, 1);

        // request held through recovery
        wait_ready();
        wr_times.delete();
        a = 16'h8C00; cpu_addr = a[15:1];
        cpu_data_in = 16'h7700; cpu_wr = 1'b1;
        repeat (9) @(negedge clk);
        cpu_wr = 1'b0;
        wait_ready();
        gap1 = (wr_times.size() >= 2) ? wr_times[1] - wr_times[0] : -1;
        chk("hold_pulses", wr_times.size(), 2);
        chk("hold_gap", gap1, 3 + REC + 1);

        // zero recovery: back-to-back accesses
        z_times.delete();
        @(negedge clk);
        z_wr = 1'b1;
        repeat (9) @(negedge clk);
        z_wr = 1'b0;
        repeat (8) @(negedge clk);
        gap1 = (z_times.size() >= 2) ? z_times[1] - z_times[0] : -1;
        gap2 = (z_times.size() >= 3) ? z_times[2] - z_times[1] : -1;
        chk("r0_pulses", z_times.size(), 3);
        chk("r0_gap1", gap1, 4);
        chk("r0_gap2", gap2, 4);

        // reset during the second rd clock
        wait_ready();
        a = 16'h8800; cpu_addr = a[15:1];
        cpu_rd = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rd_before_reset", vdp_rd, 1'b1);
        reset = 1'b1;
        cpu_rd = 1'b0;
        #1;
        chk("rd_async_drop", vdp_rd, 1'b0);
        chk("ack_async", cpu_ack, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("ready_after_reset", cpu_ready, 1'b1);
        chk("dout_after_reset", cpu_data_out, 16'h0000);
        access(16'h8C02, 16'h3400, 1'b1, 1'b0, lat, low);
        access(16'h8C02, 16'h1200, 1'b1, 1'b0, lat, low);
        access(16'h8800, 16'h0000, 1'b0, 1'b1, lat, low);
        chk("post_reset_rd", cpu_data_out, 16'h5A00);
        chk("post_reset_lat", lat, RD + 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
